// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencing controller: owns the oversampling edge counter and bit
// counter, runs the frame FSM and issues one-cycle strobes to the sampler/checkers.
module uart_rx_ctrl #(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  edge_cnt_flag,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int unsigned            BIT_W     = 4;
    localparam logic [PRESCALE_W-1:0]  P_MIN     = PRESCALE_W'(8);
    localparam logic [BIT_W-1:0]       LAST_DATA = BIT_W'(8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PRESCALE_W-1:0]   r_edge;
    logic [PRESCALE_W-1:0]   w_edge_nxt;
    logic [PRESCALE_W-1:0]   r_p;
    logic [PRESCALE_W-1:0]   w_p_nxt;
    logic [PRESCALE_W-1:0]   w_d;
    logic [PRESCALE_W-1:0]   w_d_nxt;
    logic [BIT_W-1:0]        r_bit;
    logic [BIT_W-1:0]        w_bit_nxt;
    logic                    r_par_en;
    logic                    w_par_en_nxt;
    logic                    r_par_seen;
    logic                    w_par_seen_nxt;
    logic                    w_at_d;
    logic                    w_flag;
    logic                    w_start;

    logic r_deser, r_strt, r_par, r_stp, r_dv, r_busy;
    logic w_deser_nxt, w_strt_nxt, w_par_nxt, w_stp_nxt, w_dv_nxt, w_busy_nxt;

    // Decision point D = P/2 + 2: first edge where the sampler's majority vote is valid.
    assign w_d     = PRESCALE_W'(r_p >> 1) + PRESCALE_W'(2);
    assign w_at_d  = (r_edge == w_d);
    assign w_flag  = (r_edge == (r_p - PRESCALE_W'(1)));
    assign w_start = (r_state == S_IDLE) && !RX_IN;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!RX_IN) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_at_d && strt_glitch) w_state_nxt = S_IDLE;
                else if (w_flag)           w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_flag && (r_bit == LAST_DATA))
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_flag) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // Leave at the stop decision so the rest of the stop bit is spent hunting for a start edge.
                if (w_at_d) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter, latched-configuration and parity-result next values.
    always_comb begin
        w_edge_nxt     = r_edge + PRESCALE_W'(1);
        w_bit_nxt      = r_bit;
        w_p_nxt        = r_p;
        w_par_en_nxt   = r_par_en;
        w_par_seen_nxt = r_par_seen;
        if (w_start) begin
            w_edge_nxt   = PRESCALE_W'(1);
            w_bit_nxt    = '0;
            w_p_nxt      = (prescale < P_MIN) ? P_MIN : prescale;
            w_par_en_nxt = PAR_EN;
        end else if (w_state_nxt == S_IDLE) begin
            w_edge_nxt     = '0;
            w_bit_nxt      = '0;
            w_par_seen_nxt = 1'b0;
        end else if (w_flag) begin
            w_edge_nxt = '0;
            w_bit_nxt  = r_bit + BIT_W'(1);
        end
        if ((r_state == S_PARITY) && w_at_d) w_par_seen_nxt = par_err;
    end

    assign w_d_nxt = PRESCALE_W'(w_p_nxt >> 1) + PRESCALE_W'(2);

    // Strobes are registered: decode them from the state/counter values of the next cycle.
    always_comb begin
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_strt_nxt  = (w_state_nxt == S_START)  && (w_edge_nxt == w_d_nxt);
        w_deser_nxt = (w_state_nxt == S_DATA)   && (w_edge_nxt == w_d_nxt);
        w_par_nxt   = (w_state_nxt == S_PARITY) && (w_edge_nxt == w_d_nxt);
        w_stp_nxt   = (w_state_nxt == S_STOP)   && (w_edge_nxt == w_d_nxt);
        w_dv_nxt    = (r_state == S_STOP) && w_at_d && !stp_err && !r_par_seen;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_edge     <= '0;
            r_bit      <= '0;
            r_p        <= P_MIN;
            r_par_en   <= 1'b0;
            r_par_seen <= 1'b0;
            r_busy     <= 1'b0;
            r_strt     <= 1'b0;
            r_deser    <= 1'b0;
            r_par      <= 1'b0;
            r_stp      <= 1'b0;
            r_dv       <= 1'b0;
        end else begin
            r_edge     <= w_edge_nxt;
            r_bit      <= w_bit_nxt;
            r_p        <= w_p_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_seen <= w_par_seen_nxt;
            r_busy     <= w_busy_nxt;
            r_strt     <= w_strt_nxt;
            r_deser    <= w_deser_nxt;
            r_par      <= w_par_nxt;
            r_stp      <= w_stp_nxt;
            r_dv       <= w_dv_nxt;
        end
    end

    assign edge_cnt      = r_edge;
    assign bit_cnt       = r_bit;
    assign edge_cnt_flag = w_flag;
    assign dat_samp_en   = r_busy;
    assign busy          = r_busy;
    assign strt_chk_en   = r_strt;
    assign deser_en      = r_deser;
    assign par_chk_en    = r_par;
    assign stp_chk_en    = r_stp;
    assign data_valid    = r_dv;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed and random frames checked cycle by cycle against
// an arithmetic model of where each strobe and counter value must fall relative to t0.
module tb_uart_rx_ctrl;

    localparam int unsigned PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          RX_IN;
    logic [PW-1:0] prescale;
    logic          PAR_EN;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          edge_cnt_flag;
    logic          dat_samp_en;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          data_valid;
    logic          busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    uart_rx_ctrl #(.PRESCALE_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .RX_IN         (RX_IN),
        .prescale      (prescale),
        .PAR_EN        (PAR_EN),
        .strt_glitch   (strt_glitch),
        .par_err       (par_err),
        .stp_err       (stp_err),
        .edge_cnt      (edge_cnt),
        .bit_cnt       (bit_cnt),
        .edge_cnt_flag (edge_cnt_flag),
        .dat_samp_en   (dat_samp_en),
        .deser_en      (deser_en),
        .strt_chk_en   (strt_chk_en),
        .par_chk_en    (par_chk_en),
        .stp_chk_en    (stp_chk_en),
        .data_valid    (data_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Inputs are already driven for this cycle; check outputs mid-cycle, then advance.
    task automatic tick(input int e_edge, input int e_bit, input logic [7:0] e_ctl);
        @(negedge clk);
        chk("edge_cnt", 32'(edge_cnt), 32'(e_edge));
        chk("bit_cnt", 32'(bit_cnt), 32'(e_bit));
        chk("ctl{flag,samp,busy,strt,deser,par,stp,dv}",
            32'({edge_cnt_flag, dat_samp_en, busy, strt_chk_en, deser_en,
                 par_chk_en, stp_chk_en, data_valid}),
            32'(e_ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int g = 0; g < n; g++) begin
            RX_IN       = 1'b1;
            strt_glitch = 1'b0;
            par_err     = 1'b0;
            stp_err     = 1'b0;
            tick(0, 0, 8'h00);
        end
    endtask

    // One frame starting at t0 = first cycle of the call. rst_at >= 0 aborts with reset there.
    task automatic run_frame(input int p_in, input bit pen, input logic [7:0] data,
                             input bit perr, input bit serr, input bit glitch,
                             input int gap, input int rst_at);
        int         p, d, stop_r, last, b;
        bit         act, e_flag, e_strt, e_deser, e_par, e_stp, e_dv;
        logic       rx;
        logic [7:0] ctl;
        p      = (p_in < 8) ? 8 : p_in;
        d      = p / 2 + 2;
        stop_r = (pen ? 10 : 9) * p + d;
        last   = glitch ? d : stop_r;
        for (int r = 0; r <= last + 1; r++) begin
            b = r / p;
            if (glitch)      rx = (r < 3) ? 1'b0 : 1'b1;
            else if (b == 0) rx = 1'b0;
            else if (b <= 8) rx = data[b-1];
            else if (b == 9 && pen) rx = ^data;
            else             rx = 1'b1;
            RX_IN       = rx;
            prescale    = (r == 0) ? PW'(p_in) : ((p == 32) ? PW'(8) : PW'(32));
            PAR_EN      = (r == 0) ? pen : ~pen;
            strt_glitch = glitch;
            par_err     = perr;
            stp_err     = serr;
            if (r == rst_at) begin
                rst   = 1'b0;
                RX_IN = 1'b0;
            end
            act     = (r >= 1) && (r <= last);
            e_flag  = act && (r % p == p - 1);
            e_strt  = (r == d);
            e_deser = !glitch && (r >= p + d) && (r <= 8 * p + d) && ((r - d) % p == 0);
            e_par   = !glitch && pen && (r == 9 * p + d);
            e_stp   = !glitch && (r == stop_r);
            e_dv    = !glitch && (r == stop_r + 1) && !serr && !(pen && perr);
            ctl     = {e_flag, act, act, e_strt, e_deser, e_par, e_stp, e_dv};
            tick(act ? r % p : 0, act ? r / p : 0, ctl);
            if (r == rst_at) break;
        end
        if (rst_at >= 0) begin
            rst   = 1'b1;
            RX_IN = 1'b1;
            tick(0, 0, 8'h00);
            tick(0, 0, 8'h00);
        end
        idle_cycles(gap);
    endtask

    initial begin
        int         p;
        bit         pen, perr, serr, gl;
        logic [7:0] data;

        rst         = 1'b0;
        RX_IN       = 1'b0;
        prescale    = PW'(8);
        PAR_EN      = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        RX_IN = 1'b1;
        tick(0, 0, 8'h00);
        idle_cycles(2);

        run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 3, -1);
        run_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 2, -1);
        run_frame(8, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 2, -1);
        run_frame(8, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 2, -1);
        run_frame(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4, -1);
        run_frame(8, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 0, -1);
        run_frame(8, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 2, -1);
        run_frame(8, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1, -1);
        run_frame(5, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1, -1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            pen  = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            perr = ($urandom_range(0, 3) == 0);
            serr = ($urandom_range(0, 3) == 0);
            gl   = ($urandom_range(0, 7) == 0);
            run_frame(p, pen, data, perr, serr, gl, int'($urandom_range(0, 4)), -1);
        end

        run_frame(32, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 2, 100);
        run_frame(8, 1'b0, 8'h69, 1'b0, 1'b0, 1'b0, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART receiver datapath. It owns the oversampling edge counter and the bit counter, runs the frame state machine, and issues one-cycle strobes to the data sampler, deserializer, parity, start and stop checkers. It reports a clean frame with `data_valid`. It sits between `RX_IN` and the existing sampler/checker/deserializer blocks, and its counters feed the receiver's `edge_cnt_flag` and `bit_cnt` observation points.

## Interface
- `PRESCALE_W`, 6: width of `prescale` and `edge_cnt`.
- `clk`  in  1  receiver clock; every register updates on the rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-low.
- `RX_IN`  in  1  serial line, idle high.
- `prescale`  in  PRESCALE_W  oversampling ratio; legal values are 8, 16 and 32.
- `PAR_EN`  in  1  parity bit present in the frame.
- `strt_glitch`  in  1  start checker result; valid in the cycle `strt_chk_en`=1.
- `par_err`  in  1  parity checker result; valid in the cycle `par_chk_en`=1.
- `stp_err`  in  1  stop checker result; valid in the cycle `stp_chk_en`=1.
- `edge_cnt`  out  PRESCALE_W  clock position inside the current bit, 0..P-1.
- `bit_cnt`  out  4  frame bit index: 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop when parity is present.
- `edge_cnt_flag`  out  1  high when `edge_cnt` == P-1.
- `dat_samp_en`  out  1  sampler enable; high in every non-IDLE state.
- `deser_en`  out  1  one-cycle strobe: shift `sampled_bit` into the deserializer.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en`  out  1 each  one-cycle checker strobes.
- `data_valid`  out  1  one-cycle pulse: the frame completed with no error.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- P is the latched prescale. P and the latched PAR_EN are captured on the IDLE->START transition. Changes to `prescale` or `PAR_EN` mid-frame have no effect until the next frame.
- Decision point D = P/2 + 2. This is the first edge at which the sampler's majority result for the current bit is valid. D is 6, 10 and 18 for P = 8, 16 and 32.
- States and transitions:
  - IDLE: `edge_cnt`=0, `bit_cnt`=0. If `RX_IN`=0 at a clock edge, go to START with `edge_cnt`=1. That cycle counts as edge 0 of the start bit.
  - START: at `edge_cnt`==D, pulse `strt_chk_en`. If `strt_glitch`=1 in that cycle, go to IDLE next and clear both counters. Otherwise, at `edge_cnt_flag`, go to DATA with `bit_cnt`=1 and `edge_cnt`=0.
  - DATA: pulse `deser_en` at D of each bit; data is LSB first. At `edge_cnt_flag`, increment `bit_cnt`. After bit 8, go to PARITY if PAR_EN=1, otherwise go to STOP.
  - PARITY: at D, pulse `par_chk_en` and register `par_err` into `par_seen`. A parity error does not abort the frame. At `edge_cnt_flag`, go to STOP.
  - STOP: at D, pulse `stp_chk_en`. The next cycle is IDLE, with counters cleared and `par_seen` cleared. In that IDLE cycle `data_valid`=1 only if `stp_err`=0 and `par_seen`=0.
- The remainder of the stop bit is spent in IDLE, so a start edge arriving right after the stop bit is caught. Back-to-back frames must not lose a bit.
- `edge_cnt` wraps from P-1 to 0, and `bit_cnt` increments at the same edge. `bit_cnt` never exceeds 10.
- Values of `prescale` below 8 are latched as 8. Other illegal values are unsupported.

## Timing
- Reset (`rst`=0 at a clock edge) forces the following on the next cycle, including when reset arrives mid-frame:
  - state IDLE;
  - `edge_cnt`=0, `bit_cnt`=0, `par_seen`=0;
  - all strobes 0, `data_valid`=0, `busy`=0.
- `RX_IN` low during the reset cycle does not start a frame.
- Let t0 be the cycle in which IDLE first sees `RX_IN`=0.
  - Data bit k (k = 1..8) strobe: t0 + k·P + D.
  - Parity strobe: t0 + 9P + D.
  - Stop strobe: t0 + 9P + D without parity, or t0 + 10P + D with parity.
  - `data_valid`: stop strobe + 1.
  - For P=8 this gives `data_valid` at t0+79 without parity and t0+87 with parity.
- All strobes are mutually exclusive and each lasts exactly one cycle.
- `edge_cnt_flag` is combinational from the registered `edge_cnt` and P.

## Test plan
- P=8, PAR_EN=0, frame 0xA5 with a valid stop bit:
  - `deser_en` at t0+14, 22, …, 70;
  - `data_valid`=1 at t0+79 only;
  - `bit_cnt` sequence 0..9 then back to 0.
- P=16, PAR_EN=1, frame 0x3C with correct parity and `par_err`=0, `stp_err`=0:
  - `par_chk_en` at t0+154;
  - `stp_chk_en` at t0+170;
  - `data_valid` at t0+171.
- P=8, PAR_EN=1, `par_err`=1 driven at the parity strobe:
  - frame still reaches STOP (`stp_chk_en` at t0+86);
  - `data_valid` stays 0;
  - next frame with `par_err`=0 gives `data_valid`=1.
- P=8, `RX_IN` low for 3 cycles then high, `strt_glitch`=1 at t0+6:
  - back in IDLE at t0+7;
  - `deser_en` never asserted;
  - `bit_cnt` stays 0.
- P=8, PAR_EN=0, two back-to-back frames with the second start edge one bit period after the first stop bit begins (t0+80):
  - both frames report `data_valid`, at t0+79 and t0+159.
- P=32, `rst`=0 at t0+100:
  - all outputs 0 the next cycle;
  - `data_valid` never pulses for the aborted frame;
  - `prescale` changed to 8 mid-frame is ignored until the next frame.
